// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: registered req/ack bridge from the CPU data port to NSLV
// memory-mapped slaves. Decodes the region from the upper address bits,
// drives a one-hot select for the slave read latency, and returns registered
// read data. Unmapped accesses and writes to read-only slaves complete with
// an error response and never touch a slave.
// Optional build macro: MMIO_BUS_STATS_EN enables the stat_acc/stat_err
// saturating transaction counters; without it both ports are tied to zero.
module mmio_bus_ctrl #(
  parameter int unsigned     ADDR_W  = 18,
  parameter int unsigned     DATA_W  = 32,
  parameter int unsigned     SLV_AW  = 16,
  parameter int unsigned     NSLV    = 3,
  parameter int unsigned     RD_LAT  = 2,
  parameter logic [NSLV-1:0] RO_MASK = NSLV'(3'b010)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ack,
  output logic                   cpu_err,
  output logic [NSLV-1:0]        slv_sel,
  output logic                   slv_we,
  output logic [SLV_AW-1:0]      slv_addr,
  output logic [DATA_W-1:0]      slv_wdata,
  input  logic [NSLV*DATA_W-1:0] slv_rdata,
  output logic [15:0]            stat_acc,
  output logic [15:0]            stat_err
);

  localparam int unsigned IDX_W = ADDR_W - SLV_AW;
  // RD_LAT is limited to 1..15, so a 4-bit wait counter suffices
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                cpu_err_q, cpu_err_d;
  logic [NSLV-1:0]     slv_sel_q, slv_sel_d;
  logic                slv_we_q, slv_we_d;
  logic [SLV_AW-1:0]   slv_addr_q, slv_addr_d;
  logic [DATA_W-1:0]   slv_wdata_q, slv_wdata_d;

  logic [IDX_W-1:0]    idx;
  logic [NSLV-1:0]     dec_sel;
  logic                ro_hit;
  logic                mapped;
  logic [DATA_W-1:0]   sel_rdata;

  // Region decode of the incoming CPU address into a one-hot slave select
  always_comb begin
    idx     = cpu_addr[ADDR_W-1:SLV_AW];
    dec_sel = '0;
    ro_hit  = 1'b0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (idx == IDX_W'(i)) begin
        dec_sel[i] = 1'b1;
        ro_hit     = RO_MASK[i];
      end
    end
    mapped = |dec_sel;
  end

  // Read-data mux driven by the registered (held) select
  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (slv_sel_q[i]) begin
        sel_rdata = sel_rdata | slv_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and registered-output logic of the transaction engine
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    cpu_err_d   = 1'b0;
    slv_sel_d   = slv_sel_q;
    slv_we_d    = slv_we_q;
    slv_addr_d  = slv_addr_q;
    slv_wdata_d = slv_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          slv_addr_d  = cpu_addr[SLV_AW-1:0];
          slv_wdata_d = cpu_wdata;
          if (!mapped || (cpu_we && ro_hit)) begin
            // Rejected access: answer immediately, no slave is touched
            state_d     = RESP;
            cpu_ack_d   = 1'b1;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = '0;
          end else begin
            state_d   = ACCESS;
            slv_sel_d = dec_sel;
            slv_we_d  = cpu_we;
            cnt_d     = cpu_we ? CNT_W'(1) : CNT_W'(RD_LAT);
          end
        end
      end

      ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (!slv_we_q) begin
            cpu_rdata_d = sel_rdata;
          end
          cpu_ack_d = 1'b1;
          slv_sel_d = '0;
          slv_we_d  = 1'b0;
          state_d   = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      slv_sel_q   <= '0;
      slv_we_q    <= 1'b0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_err_q   <= cpu_err_d;
      slv_sel_q   <= slv_sel_d;
      slv_we_q    <= slv_we_d;
      slv_addr_q  <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_err   = cpu_err_q;
  assign slv_sel   = slv_sel_q;
  assign slv_we    = slv_we_q;
  assign slv_addr  = slv_addr_q;
  assign slv_wdata = slv_wdata_q;

`ifdef MMIO_BUS_STATS_EN
  logic [15:0] stat_acc_q, stat_acc_d;
  logic [15:0] stat_err_q, stat_err_d;

  // Saturating counters, updated on the edge that raises cpu_ack
  always_comb begin
    stat_acc_d = stat_acc_q;
    stat_err_d = stat_err_q;
    if (cpu_ack_d && (stat_acc_q != 16'hFFFF)) begin
      stat_acc_d = stat_acc_q + 16'd1;
    end
    if (cpu_ack_d && cpu_err_d && (stat_err_q != 16'hFFFF)) begin
      stat_err_d = stat_err_q + 16'd1;
    end
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_acc_q <= '0;
      stat_err_q <= '0;
    end else begin
      stat_acc_q <= stat_acc_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_acc = stat_acc_q;
  assign stat_err = stat_err_q;
`else
  assign stat_acc = '0;
  assign stat_err = '0;
`endif

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed testbench for mmio_bus_ctrl: one instance with default parameters
// (registered slaves, RD_LAT=2) and one with RD_LAT=1 (combinational slaves)
// for back-to-back reads with cpu_req held high.
module tb_mmio_bus_ctrl;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SLV_AW = 16;
  localparam int unsigned NSLV   = 3;

`ifdef MMIO_BUS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  // default instance
  logic                   cpu_req, cpu_we, cpu_ack, cpu_err, slv_we;
  logic [ADDR_W-1:0]      cpu_addr;
  logic [DATA_W-1:0]      cpu_wdata, cpu_rdata, slv_wdata;
  logic [NSLV-1:0]        slv_sel;
  logic [SLV_AW-1:0]      slv_addr;
  logic [NSLV*DATA_W-1:0] slv_rdata;
  logic [15:0]            stat_acc, stat_err;

  // RD_LAT=1 instance
  logic                   cpu_req1, cpu_we1, cpu_ack1, cpu_err1, slv_we1;
  logic [ADDR_W-1:0]      cpu_addr1;
  logic [DATA_W-1:0]      cpu_wdata1, cpu_rdata1, slv_wdata1;
  logic [NSLV-1:0]        slv_sel1;
  logic [SLV_AW-1:0]      slv_addr1;
  logic [NSLV*DATA_W-1:0] slv_rdata1;
  logic [15:0]            stat_acc1, stat_err1;

  // per-slave read data pattern: base XOR slave-local address
  logic [DATA_W-1:0] base [NSLV];
  logic [15:0]       b2b_addr [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mmio_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata), .stat_acc(stat_acc), .stat_err(stat_err)
  );

  mmio_bus_ctrl #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
    .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1), .cpu_err(cpu_err1),
    .slv_sel(slv_sel1), .slv_we(slv_we1), .slv_addr(slv_addr1), .slv_wdata(slv_wdata1),
    .slv_rdata(slv_rdata1), .stat_acc(stat_acc1), .stat_err(stat_err1)
  );

  // Sync-BRAM style slaves: data valid one cycle after select, junk otherwise
  always @(posedge clk) begin
    for (int i = 0; i < NSLV; i++) begin
      slv_rdata[i*DATA_W +: DATA_W] <= slv_sel[i] ? (base[i] ^ {16'h0000, slv_addr})
                                                  : 32'hDEADBEEF;
    end
  end

  // Combinational slaves for the RD_LAT=1 instance
  always_comb begin
    slv_rdata1 = '0;
    for (int i = 0; i < NSLV; i++) begin
      slv_rdata1[i*DATA_W +: DATA_W] = base[i] ^ {16'h0000, slv_addr1};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_ack;
    int last_cyc;

    base[0] = 32'hA5A50000;
    base[1] = 32'h1234567C;
    base[2] = 32'h0BADF000;
    b2b_addr[0] = 16'h0000;
    b2b_addr[1] = 16'h0004;
    b2b_addr[2] = 16'h0008;

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_req1 = 1'b0; cpu_we1 = 1'b0; cpu_addr1 = '0; cpu_wdata1 = '0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_ack",   64'(cpu_ack),   64'h0);
    check("rst_err",   64'(cpu_err),   64'h0);
    check("rst_rdata", 64'(cpu_rdata), 64'h0);
    check("rst_sel",   64'(slv_sel),   64'h0);
    check("rst_we",    64'(slv_we),    64'h0);
    check("rst_addr",  64'(slv_addr),  64'h0);
    check("rst_wdata", 64'(slv_wdata), 64'h0);
    check("rst_stat",  64'({stat_acc, stat_err}), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // write to slave 0
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00010; cpu_wdata = 32'h000000A5;
    @(negedge clk);
    cpu_req = 1'b0;
    check("wr_sel",   64'(slv_sel),   64'h1);
    check("wr_addr",  64'(slv_addr),  64'h0010);
    check("wr_we",    64'(slv_we),    64'h1);
    check("wr_wdata", 64'(slv_wdata), 64'hA5);
    check("wr_early", 64'(cpu_ack),   64'h0);
    @(negedge clk);
    check("wr_ack",    64'(cpu_ack),   64'h1);
    check("wr_err",    64'(cpu_err),   64'h0);
    check("wr_we_off", 64'(slv_we),    64'h0);
    check("wr_sel_off",64'(slv_sel),   64'h0);
    check("wr_rdata",  64'(cpu_rdata), 64'h0);
    @(negedge clk);
    check("wr_ack_clr", 64'(cpu_ack), 64'h0);

    // read from slave 1 (read-only, reads allowed)
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h10004;
    @(negedge clk);
    cpu_req = 1'b0;
    check("rd_sel_c1", 64'(slv_sel), 64'h2);
    check("rd_ack_c1", 64'(cpu_ack), 64'h0);
    @(negedge clk);
    check("rd_sel_c2", 64'(slv_sel), 64'h2);
    check("rd_ack_c2", 64'(cpu_ack), 64'h0);
    @(negedge clk);
    check("rd_ack",     64'(cpu_ack),   64'h1);
    check("rd_err",     64'(cpu_err),   64'h0);
    check("rd_data",    64'(cpu_rdata), 64'h12345678);
    check("rd_sel_off", 64'(slv_sel),   64'h0);
    @(negedge clk);
    check("rd_ack_clr", 64'(cpu_ack),   64'h0);
    check("rd_hold",    64'(cpu_rdata), 64'h12345678);

    // write to slave 2 keeps cpu_rdata
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h20100; cpu_wdata = 32'hCAFEF00D;
    @(negedge clk);
    cpu_req = 1'b0;
    check("wr2_sel",  64'(slv_sel),  64'h4);
    check("wr2_addr", 64'(slv_addr), 64'h0100);
    check("wr2_we",   64'(slv_we),   64'h1);
    @(negedge clk);
    check("wr2_ack",   64'(cpu_ack),   64'h1);
    check("wr2_rdata", 64'(cpu_rdata), 64'h12345678);
    @(negedge clk);

    // write to read-only slave 1
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h10000; cpu_wdata = 32'hFFFF0000;
    @(negedge clk);
    cpu_req = 1'b0;
    check("ro_ack",   64'(cpu_ack),   64'h1);
    check("ro_err",   64'(cpu_err),   64'h1);
    check("ro_rdata", 64'(cpu_rdata), 64'h0);
    check("ro_sel",   64'(slv_sel),   64'h0);
    check("ro_we",    64'(slv_we),    64'h0);
    @(negedge clk);
    check("ro_ack_clr", 64'(cpu_ack), 64'h0);
    check("ro_err_clr", 64'(cpu_err), 64'h0);

    // unmapped read, region index 3
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h30000;
    @(negedge clk);
    cpu_req = 1'b0;
    check("um_ack", 64'(cpu_ack), 64'h1);
    check("um_err", 64'(cpu_err), 64'h1);
    check("um_sel", 64'(slv_sel), 64'h0);
    @(negedge clk);
    check("um_ack_clr", 64'(cpu_ack), 64'h0);
    check("stat_acc_pre", 64'(stat_acc), STATS ? 64'd5 : 64'd0);
    check("stat_err_pre", 64'(stat_err), STATS ? 64'd2 : 64'd0);

    // back-to-back reads with cpu_req held high, RD_LAT=1
    n_ack = 0;
    last_cyc = 0;
    cpu_req1 = 1'b1; cpu_we1 = 1'b0; cpu_addr1 = {2'b00, b2b_addr[0]};
    for (int cyc = 0; cyc < 40 && n_ack < 3; cyc++) begin
      @(negedge clk);
      if (cpu_ack1) begin
        check($sformatf("b2b_data%0d", n_ack), 64'(cpu_rdata1),
              64'(base[0] ^ {16'h0000, b2b_addr[n_ack]}));
        if (n_ack > 0) check("b2b_gap", 64'(cyc - last_cyc), 64'd3);
        last_cyc = cyc;
        n_ack++;
        if (n_ack < 3) cpu_addr1 = {2'b00, b2b_addr[n_ack]};
        else cpu_req1 = 1'b0;
      end
    end
    check("b2b_count", 64'(n_ack), 64'd3);
    repeat (2) @(negedge clk);

    // reset during the ACCESS phase of a read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00008;
    @(negedge clk);
    cpu_req = 1'b0;
    check("rr_sel_pre", 64'(slv_sel), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("rr_sel",   64'(slv_sel),   64'h0);
    check("rr_ack",   64'(cpu_ack),   64'h0);
    check("rr_addr",  64'(slv_addr),  64'h0);
    check("rr_rdata", 64'(cpu_rdata), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rr_no_ack", 64'(cpu_ack), 64'h0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00008;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    check("rr2_ack_c2", 64'(cpu_ack), 64'h0);
    @(negedge clk);
    check("rr2_ack",  64'(cpu_ack),   64'h1);
    check("rr2_data", 64'(cpu_rdata), 64'hA5A50008);
    @(negedge clk);
    check("stat_acc_post", 64'(stat_acc), STATS ? 64'd1 : 64'd0);
    check("stat_err_post", 64'(stat_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
